axi_slave_arbiter: RTL
======================

Name: axi_slave_arbiter

Overview:
Two-master to one-slave arbiter for single-beat AXI write and read transactions (awlen/arlen = 0) in front of the 8-word AXI slave memory. The write path and the read path are arbitrated independently, each with round-robin priority. The arbiter steers the granted master's address/data handshakes to the slave and routes responses back. The granted master index is driven on the slave's awid/arid.

Parameters:
ADDR_WIDTH, 3, address width per master and to slave
DATA_WIDTH, 32, data width
STRB_WIDTH, 4, write strobe width (DATA_WIDTH/8)
RESP_WIDTH, 2, bresp/rresp width

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
m_awvalid  in  2  per-master write address valid (bit i = master i)
m_awaddr  in  2*ADDR_WIDTH  packed; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_awready  out  2  per-master write address ready
m_wvalid  in  2  per-master write data valid
m_wdata  in  2*DATA_WIDTH  packed write data
m_wstrb  in  2*STRB_WIDTH  packed strobes
m_wready  out  2  per-master write data ready
m_bvalid  out  2  per-master write response valid
m_bresp  out  RESP_WIDTH  write response (shared; qualified by m_bvalid)
m_bready  in  2  per-master write response ready
m_arvalid  in  2  per-master read address valid
m_araddr  in  2*ADDR_WIDTH  packed read address
m_arready  out  2  per-master read address ready
m_rvalid  out  2  per-master read data valid
m_rdata  out  DATA_WIDTH  read data (shared)
m_rresp  out  RESP_WIDTH  read response (shared)
m_rready  in  2  per-master read data ready
s_awid, s_awvalid  out  1,1  slave write address id (= write grant index), valid
s_awaddr  out  ADDR_WIDTH  slave write address
s_awready  in  1  slave write address ready
s_wvalid  out  1  slave write data valid
s_wdata  out  DATA_WIDTH  slave write data
s_wstrb  out  STRB_WIDTH  slave write strobes
s_wlast  out  1  tied 1 (single beat)
s_wready  in  1  slave write data ready
s_bvalid, s_bresp  in  1,RESP_WIDTH  slave write response
s_bready  out  1  slave write response ready
s_arid, s_arvalid  out  1,1  slave read address id (= read grant index), valid
s_araddr  out  ADDR_WIDTH  slave read address
s_arready  in  1  slave read address ready
s_rvalid, s_rdata, s_rresp  in  1,DATA_WIDTH,RESP_WIDTH  slave read data
s_rready  out  1  slave read data ready

Behaviour:
- Write FSM states: WI (idle), WA (address/data forwarding), WB (response).
- WI: request_i = m_awvalid[i]. If any request: wgnt <= winner, go to WA; aw_done and w_done cleared.
- Round robin: a lone requester wins. If both request, the master != wlast wins. wlast resets to 1, so master 0 wins the first tie.
- WA, forwarding:
  - s_awvalid = m_awvalid[wgnt] & ~aw_done; m_awready[wgnt] = s_awready & ~aw_done.
  - s_wvalid = m_wvalid[wgnt] & ~w_done; m_wready[wgnt] = s_wready & ~w_done.
  - Payload muxed from wgnt. The AW and W handshakes may complete in the same cycle or in either order; each sets its done flag.
  - Once both are done (including same-cycle completion), go to WB.
- WB: m_bvalid[wgnt] = s_bvalid; s_bready = m_bready[wgnt]; m_bresp = s_bresp. On s_bvalid & s_bready: wlast <= wgnt, go to WI.
- Earliest next grant is the cycle after the B handshake (one-cycle WI bubble).
- Read FSM states: RI, RA, RD. Same grant rule using m_arvalid and pointer rlast (reset 1).
  - RA forwards AR until s_arvalid & s_arready, then goes to RD.
  - RD routes s_rvalid/s_rdata/s_rresp to the granted master and m_rready[rgnt] to s_rready. On the R handshake: rlast <= rgnt, go to RI.
- Write and read FSMs run fully concurrently. No ordering is enforced between them; write/read hazard handling stays in the slave.
- All outputs are combinational from state plus inputs. Non-granted masters see ready = 0 and valid = 0.
- Outside WA/RA: s_awvalid, s_wvalid and s_arvalid are 0.
- Outside WB/RD: s_bready, s_rready, m_bvalid and m_rvalid are 0.
- m_rdata and m_rresp pass through s_rdata/s_rresp; m_bresp passes through s_bresp.
- A grant is locked until the response handshake completes. A master dropping valid mid-grant is a protocol violation; the arbiter keeps waiting.
- Reset (async, any time): FSMs to WI/RI, done flags 0, wgnt = rgnt = 0, wlast = rlast = 1. All valid/ready outputs go to 0 immediately. An in-flight transaction is abandoned.

Optional Feature:
ARB_STATS_EN:
- When defined, adds output ports wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1 (16 bits each).
- Each counter counts completed B (or R) handshakes for that master, saturates at 16'hFFFF, and resets to 0.
- When undefined, the ports and counters are absent.

Test Plan:
- Only m0 writes addr 3, data 32'hA5A5_0001 (AW and W same cycle); slave readies 1, bresp 00 -> s_awid=0, s_awaddr=3, m_bvalid=2'b01, m_bresp=00; back in WI one cycle after B.
- m0 and m1 both assert awvalid in the same cycle from reset -> m0 served first; m1 granted in the first WI cycle after m0's B handshake; s_awid=1 on the second transaction.
- Granted master issues W two cycles before AW, with s_wready held -> w_done set, s_wvalid deasserts, WB entered only after the AW handshake; exactly one s_wvalid&s_wready pulse.
- Concurrent: m0 writes addr 5 while m1 reads addr 2 (slave returns rresp 2'b10) -> both complete independently; m_rvalid=2'b10, m_rresp=10.
- Reset asserted in WB with s_bvalid pending -> all outputs 0 same cycle; after release a single m1 request is granted (tie pointer back to 1).
- With ARB_STATS_EN: 3 m0 writes and 2 m1 reads -> wr_cnt0=3, rd_cnt1=2, others 0.

Source files
------------

// File: rtl/axi_slave_arbiter.sv
// Two-master to one-slave arbiter for single-beat AXI writes and reads.
// The write and read paths arbitrate independently with round-robin priority
// and forward the granted master's handshakes to the slave.
// Optional build macro ARB_STATS_EN adds per-master completion counters
// (wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1).
//
// Write FSM
//   state | meaning
//   WI    | idle, waiting for any m_awvalid
//   WA    | forwarding AW and W of the granted master until both accepted
//   WB    | routing the write response back to the granted master
// Read FSM
//   state | meaning
//   RI    | idle, waiting for any m_arvalid
//   RA    | forwarding AR of the granted master until accepted
//   RD    | routing read data back to the granted master
module axi_slave_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int RESP_WIDTH = 2
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [1:0]                m_awvalid,
    input  logic [2*ADDR_WIDTH-1:0]   m_awaddr,
    output logic [1:0]                m_awready,
    input  logic [1:0]                m_wvalid,
    input  logic [2*DATA_WIDTH-1:0]   m_wdata,
    input  logic [2*STRB_WIDTH-1:0]   m_wstrb,
    output logic [1:0]                m_wready,
    output logic [1:0]                m_bvalid,
    output logic [RESP_WIDTH-1:0]     m_bresp,
    input  logic [1:0]                m_bready,
    input  logic [1:0]                m_arvalid,
    input  logic [2*ADDR_WIDTH-1:0]   m_araddr,
    output logic [1:0]                m_arready,
    output logic [1:0]                m_rvalid,
    output logic [DATA_WIDTH-1:0]     m_rdata,
    output logic [RESP_WIDTH-1:0]     m_rresp,
    input  logic [1:0]                m_rready,
    output logic                      s_awid,
    output logic                      s_awvalid,
    output logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awready,
    output logic                      s_wvalid,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [STRB_WIDTH-1:0]     s_wstrb,
    output logic                      s_wlast,
    input  logic                      s_wready,
    input  logic                      s_bvalid,
    input  logic [RESP_WIDTH-1:0]     s_bresp,
    output logic                      s_bready,
    output logic                      s_arid,
    output logic                      s_arvalid,
    output logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    input  logic [RESP_WIDTH-1:0]     s_rresp,
    output logic                      s_rready
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]               wr_cnt0,
    output logic [15:0]               wr_cnt1,
    output logic [15:0]               rd_cnt0,
    output logic [15:0]               rd_cnt1
`endif
);

    typedef enum logic [1:0] {WI, WA, WB} wstate_t;
    typedef enum logic [1:0] {RI, RA, RD} rstate_t;

    wstate_t wstate;
    rstate_t rstate;
    logic    wgnt, wlast, aw_done, w_done;
    logic    rgnt, rlast;
    logic    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Lone requester wins; on a tie the master that did not win last time goes.
    function automatic logic pick(input logic [1:0] req, input logic last);
        if (req == 2'b11)
            return ~last;
        return req[1];
    endfunction

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;

    // Write-side steering: payload always muxed from the grant, handshakes gated by state.
    always_comb begin
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_awid    = wgnt;
        s_awaddr  = wgnt ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_awaddr[ADDR_WIDTH-1:0];
        s_wdata   = wgnt ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
        s_wstrb   = wgnt ? m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : m_wstrb[STRB_WIDTH-1:0];
        s_wlast   = 1'b1;
        m_bresp   = s_bresp;
        case (wstate)
            WA: begin
                s_awvalid       = m_awvalid[wgnt] & ~aw_done;
                m_awready[wgnt] = s_awready & ~aw_done;
                s_wvalid        = m_wvalid[wgnt] & ~w_done;
                m_wready[wgnt]  = s_wready & ~w_done;
            end
            WB: begin
                m_bvalid[wgnt] = s_bvalid;
                s_bready       = m_bready[wgnt];
            end
            default: ;
        endcase
    end

    // Read-side steering: same scheme as the write side.
    always_comb begin
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_arid    = rgnt;
        s_araddr  = rgnt ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
        m_rdata   = s_rdata;
        m_rresp   = s_rresp;
        case (rstate)
            RA: begin
                s_arvalid       = m_arvalid[rgnt];
                m_arready[rgnt] = s_arready;
            end
            RD: begin
                m_rvalid[rgnt] = s_rvalid;
                s_rready       = m_rready[rgnt];
            end
            default: ;
        endcase
    end

    // Write FSM: grant, collect AW and W acceptance in any order, then wait for B.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate  <= WI;
            wgnt    <= 1'b0;
            wlast   <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (wstate)
                WI: begin
                    if (|m_awvalid) begin
                        wgnt    <= pick(m_awvalid, wlast);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        wstate  <= WA;
                    end
                end
                WA: begin
                    if (aw_hs)
                        aw_done <= 1'b1;
                    if (w_hs)
                        w_done <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs))
                        wstate <= WB;
                end
                WB: begin
                    if (b_hs) begin
                        wlast  <= wgnt;
                        wstate <= WI;
                    end
                end
                default: wstate <= WI;
            endcase
        end
    end

    // Read FSM: grant, forward AR, then wait for the R beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rstate <= RI;
            rgnt   <= 1'b0;
            rlast  <= 1'b1;
        end else begin
            case (rstate)
                RI: begin
                    if (|m_arvalid) begin
                        rgnt   <= pick(m_arvalid, rlast);
                        rstate <= RA;
                    end
                end
                RA: begin
                    if (ar_hs)
                        rstate <= RD;
                end
                RD: begin
                    if (r_hs) begin
                        rlast  <= rgnt;
                        rstate <= RI;
                    end
                end
                default: rstate <= RI;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating count of completed write responses per master.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_cnt0 <= '0;
            wr_cnt1 <= '0;
        end else if (b_hs) begin
            if (!wgnt && wr_cnt0 != 16'hFFFF)
                wr_cnt0 <= wr_cnt0 + 16'd1;
            if (wgnt && wr_cnt1 != 16'hFFFF)
                wr_cnt1 <= wr_cnt1 + 16'd1;
        end
    end

    // Saturating count of completed read beats per master.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_cnt0 <= '0;
            rd_cnt1 <= '0;
        end else if (r_hs) begin
            if (!rgnt && rd_cnt0 != 16'hFFFF)
                rd_cnt0 <= rd_cnt0 + 16'd1;
            if (rgnt && rd_cnt1 != 16'hFFFF)
                rd_cnt1 <= rd_cnt1 + 16'd1;
        end
    end
`endif

endmodule
